// File: rtl/rgb_pixel_sender_pkg.sv
// Shared definitions for the RGB pixel sender: default sizes, channel tags and FSM states.
package rgb_pixel_sender_pkg;

  localparam int NPIX_DEF = 16384;
  localparam int AW_DEF   = 14;
  localparam int DW_DEF   = 8;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PASS_R   = 3'd1,
    ST_PASS_G   = 3'd2,
    ST_PASS_B   = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_WAIT_DIV = 3'd5
  } state_t;

  // Channel tag attached to a read issued while in the given pass.
  function automatic ch_t pass_channel(input state_t st);
    case (st)
      ST_PASS_R: pass_channel = CH_R;
      ST_PASS_G: pass_channel = CH_G;
      ST_PASS_B: pass_channel = CH_B;
      default:   pass_channel = CH_R;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pixel_sender_addr_counter.sv
// Pixel RAM address counter: clears, advances on en, wraps explicitly at NPIX-1.
module pixel_addr_counter #(
  parameter int NPIX = 16384,
  parameter int AW   = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Next count: clear wins, wrap at the terminal value rather than on overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : (cnt_q + AW'(1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_pixel_sender.sv
// Streams a picture from pixel RAM to the R/G/B accumulators as three channel passes,
// then pulses one_picture and waits for the divider's renew_index.
module rgb_pixel_sender
  import rgb_pixel_sender_pkg::*;
#(
  parameter int NPIX = NPIX_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [3*DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          Radd_en,
  output logic          Gadd_en,
  output logic          Badd_en,
  output logic          one_picture,
  input  logic          renew_index,
  output logic          busy
);

  state_t        state_q;
  state_t        state_d;
  logic          issue_s;
  logic          clr_s;
  logic          tc_s;
  logic [AW-1:0] cnt_s;

  logic          vld_q;
  ch_t           tag_q;
  logic [DW-1:0] pix_hold_q;
  logic [DW-1:0] sel_byte_s;

  pixel_addr_counter #(
    .NPIX (NPIX),
    .AW   (AW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (issue_s),
    .clr_i (clr_s),
    .cnt_o (cnt_s),
    .tc_o  (tc_s)
  );

  // Next-state and read-issue decode.
  always_comb begin
    state_d = state_q;
    issue_s = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PASS_R;
          clr_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS_R: begin
        issue_s = !pause;
        state_d = (issue_s && tc_s) ? ST_PASS_G : ST_PASS_R;
      end
      ST_PASS_G: begin
        issue_s = !pause;
        state_d = (issue_s && tc_s) ? ST_PASS_B : ST_PASS_G;
      end
      ST_PASS_B: begin
        issue_s = !pause;
        state_d = (issue_s && tc_s) ? ST_FLUSH : ST_PASS_B;
      end
      ST_FLUSH: begin
        state_d = ST_WAIT_DIV;
      end
      ST_WAIT_DIV: begin
        state_d = renew_index ? ST_IDLE : ST_WAIT_DIV;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read-return pipeline: the tag travels with the read so pass boundaries never mislabel.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= 1'b0;
      tag_q      <= CH_R;
      pix_hold_q <= '0;
    end else begin
      vld_q <= issue_s;
      if (issue_s) begin
        tag_q <= pass_channel(state_q);
      end
      if (vld_q) begin
        pix_hold_q <= sel_byte_s;
      end
    end
  end

  // Channel byte select from the returning RAM word.
  always_comb begin
    sel_byte_s = pix_hold_q;
    case (tag_q)
      CH_R:    sel_byte_s = mem_rdata[3*DW-1:2*DW];
      CH_G:    sel_byte_s = mem_rdata[2*DW-1:DW];
      CH_B:    sel_byte_s = mem_rdata[DW-1:0];
      default: sel_byte_s = pix_hold_q;
    endcase
  end

  assign mem_rd_en   = issue_s;
  assign mem_addr    = cnt_s;
  assign pix_data    = vld_q ? sel_byte_s : pix_hold_q;
  assign Radd_en     = vld_q && (tag_q == CH_R);
  assign Gadd_en     = vld_q && (tag_q == CH_G);
  assign Badd_en     = vld_q && (tag_q == CH_B);
  assign one_picture = vld_q && (state_q == ST_FLUSH);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgb_pixel_sender.sv
// Directed bench for rgb_pixel_sender with an 8-pixel picture and a synthetic RAM model.
module tb_rgb_pixel_sender;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       renew_index = 1'b0;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [23:0] mem_rdata = 24'h0;
  logic [7:0] pix_data;
  logic       Radd_en, Gadd_en, Badd_en, one_picture, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int log_byte[$];
  int log_ch[$];
  int log_cyc[$];
  int op_cyc[$];
  int op_byte[$];
  int onehot_err = 0;

  rgb_pixel_sender #(.NPIX(8), .AW(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .Radd_en(Radd_en), .Gadd_en(Gadd_en), .Badd_en(Badd_en),
    .one_picture(one_picture), .renew_index(renew_index), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word[i] = {10+i, 20+i, 30+i}, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= {8'h10 + {4'h0, mem_addr}, 8'h20 + {4'h0, mem_addr}, 8'h30 + {4'h0, mem_addr}};
  end

  always @(negedge clk) begin
    if (Radd_en || Gadd_en || Badd_en) begin
      log_byte.push_back(int'(pix_data));
      log_ch.push_back(Radd_en ? 0 : (Gadd_en ? 1 : 2));
      log_cyc.push_back(cyc);
    end
    if ((int'(Radd_en) + int'(Gadd_en) + int'(Badd_en)) > 1) onehot_err++;
    if (one_picture) begin
      op_cyc.push_back(cyc);
      op_byte.push_back(int'(pix_data));
    end
  end

  function automatic int exp_byte(input int i);
    return 16 * (i / 8 + 1) + (i % 8);
  endfunction

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_byte.delete(); log_ch.delete(); log_cyc.delete();
    op_cyc.delete(); op_byte.delete();
  endtask

  task automatic start_pic(output int s);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic renew_pulse();
    renew_index = 1'b1;
    @(posedge clk); #1;
    renew_index = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_rd_en, one_picture, Radd_en, Gadd_en, Badd_en} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, mem_rd_en, one_picture, Radd_en, Gadd_en, Badd_en});
    end
    checks++;
    if (mem_addr !== 4'h0 || pix_data !== 8'h00) begin
      errors++; $display("FAIL reset_data addr %h pix %h want 0 0", mem_addr, pix_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int s;
    clear_log();
    start_pic(s);
    goto_cyc(s + 30);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    checks++;
    if (log_byte.size() != 24) begin errors++; $display("FAIL single_count got %0d want 24", log_byte.size()); end
    for (int i = 0; i < log_byte.size() && i < 24; i++) begin
      checks++;
      if (log_byte[i] != exp_byte(i) || log_ch[i] != i / 8) begin
        errors++; $display("FAIL single_byte[%0d] got %h/ch%0d want %h/ch%0d", i, log_byte[i], log_ch[i], exp_byte(i), i / 8);
      end
      checks++;
      if (log_cyc[i] != s + 2 + i) begin
        errors++; $display("FAIL single_cyc[%0d] got %0d want %0d", i, log_cyc[i] - s, 2 + i);
      end
    end
    checks++;
    if (op_cyc.size() != 1) begin
      errors++; $display("FAIL single_op_count got %0d want 1", op_cyc.size());
    end else begin
      checks++;
      if (op_cyc[0] != s + 25 || op_byte[0] != 8'h37) begin
        errors++; $display("FAIL single_op at %0d byte %h want 25 37", op_cyc[0] - s, op_byte[0]);
      end
    end
    @(posedge clk); #1;
    renew_pulse();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_release busy %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_pause();
    int s;
    clear_log();
    start_pic(s);
    goto_cyc(s + 14);
    pause = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL pause_rd got %b want 0", mem_rd_en); end
    goto_cyc(s + 17);
    pause = 1'b0;
    goto_cyc(s + 32);
    checks++;
    if (log_byte.size() != 24) begin errors++; $display("FAIL pause_count got %0d want 24", log_byte.size()); end
    for (int i = 0; i < log_byte.size() && i < 24; i++) begin
      checks++;
      if (log_byte[i] != exp_byte(i) || log_ch[i] != i / 8) begin
        errors++; $display("FAIL pause_byte[%0d] got %h want %h", i, log_byte[i], exp_byte(i));
      end
    end
    if (log_cyc.size() >= 14) begin
      checks++;
      if (log_cyc[12] != s + 14 || log_cyc[13] != s + 18) begin
        errors++; $display("FAIL pause_gap got %0d,%0d want 14,18", log_cyc[12] - s, log_cyc[13] - s);
      end
    end
    checks++;
    if (op_cyc.size() != 1 || op_cyc[0] != s + 28) begin
      errors++; $display("FAIL pause_op count %0d want 1 at 28", op_cyc.size());
    end
    renew_pulse();
    @(posedge clk); #1;
  endtask

  task automatic test_early_renew();
    int s;
    clear_log();
    start_pic(s);
    goto_cyc(s + 3);
    renew_index = 1'b1;
    goto_cyc(s + 4);
    renew_index = 1'b0;
    goto_cyc(s + 30);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || op_cyc.size() != 1 || log_byte.size() != 24) begin
      errors++; $display("FAIL early_renew busy %b op %0d bytes %0d want 1 1 24", busy, op_cyc.size(), log_byte.size());
    end
    @(posedge clk); #1;
    renew_pulse();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL early_renew_release busy %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int s;
    clear_log();
    start = 1'b1;
    s = cyc;
    goto_cyc(s + 35);
    @(negedge clk);
    checks++;
    if (log_byte.size() != 24 || busy !== 1'b1) begin
      errors++; $display("FAIL held_wait bytes %0d busy %b want 24 1", log_byte.size(), busy);
    end
    renew_index = 1'b1;
    goto_cyc(s + 36);
    renew_index = 1'b0;
    goto_cyc(s + 37);
    start = 1'b0;
    goto_cyc(s + 64);
    checks++;
    if (log_byte.size() != 48) begin
      errors++; $display("FAIL held_count got %0d want 48", log_byte.size());
    end else begin
      checks++;
      if (log_cyc[24] != s + 38 || log_byte[24] != 8'h10) begin
        errors++; $display("FAIL held_second at %0d byte %h want 38 10", log_cyc[24] - s, log_byte[24]);
      end
    end
    checks++;
    if (op_cyc.size() != 2 || op_cyc[1] != s + 61) begin
      errors++; $display("FAIL held_op count %0d want 2 (second at 61)", op_cyc.size());
    end
    renew_pulse();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int s;
    clear_log();
    start_pic(s);
    goto_cyc(s + 20);
    reset = 1'b1;
    goto_cyc(s + 21);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_rd_en, one_picture, Radd_en, Gadd_en, Badd_en} !== 6'b0 || pix_data !== 8'h00 || mem_addr !== 4'h0) begin
      errors++; $display("FAIL midreset_out ctrl %b pix %h addr %h want 0", {busy, mem_rd_en, one_picture, Radd_en, Gadd_en, Badd_en}, pix_data, mem_addr);
    end
    checks++;
    if (log_byte.size() != 19) begin errors++; $display("FAIL midreset_bytes got %0d want 19", log_byte.size()); end
    @(posedge clk); #1;
    clear_log();
    start_pic(s);
    goto_cyc(s + 30);
    checks++;
    if (log_byte.size() != 24 || op_cyc.size() != 1) begin
      errors++; $display("FAIL midreset_replay bytes %0d op %0d want 24 1", log_byte.size(), op_cyc.size());
    end else begin
      checks++;
      if (log_byte[0] != 8'h10 || log_byte[23] != 8'h37) begin
        errors++; $display("FAIL midreset_first got %h..%h want 10..37", log_byte[0], log_byte[23]);
      end
    end
    renew_pulse();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int s, n;
    int sum[3];
    int cnt[3];
    int want[3] = '{156, 284, 412};
    for (int p = 0; p < 20; p++) begin
      clear_log();
      start_pic(s);
      n = 0;
      while (op_cyc.size() == 0 && n < 300) begin
        pause = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        n++;
      end
      pause = 1'b0;
      checks++;
      if (op_cyc.size() == 0) begin
        errors++; $display("FAIL random_timeout pic %0d got no one_picture want 1", p);
      end
      for (int c = 0; c < 3; c++) begin sum[c] = 0; cnt[c] = 0; end
      for (int i = 0; i < log_byte.size(); i++) begin
        sum[log_ch[i]] += log_byte[i];
        cnt[log_ch[i]]++;
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sum[c] != want[c] || cnt[c] != 8) begin
          errors++; $display("FAIL random_sum pic %0d ch %0d sum %0d cnt %0d want %0d 8", p, c, sum[c], cnt[c], want[c]);
        end
      end
      renew_pulse();
      @(posedge clk); #1;
    end
    checks++;
    if (onehot_err != 0) begin errors++; $display("FAIL onehot got %0d overlaps want 0", onehot_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pause();
    test_early_renew();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
